fpa_normalize_pack: RTL
=======================

// Module: fpa_normalize_pack
// PURPOSE
//  Back end of the FP adder pipeline: takes raw signed-magnitude sum (sign, larger exponent,
//  unnormalised 32-bit mantissa) from the align/add stage and returns a packed IEEE-754 single.
//  Iterative: one shift per cycle, round-to-nearest-even, valid/ready on both sides.
// PARAMETERS
//  EXP_W   8   exponent width
//  FRAC_W  23  stored fraction width; hidden bit sits at in_mant[FRAC_W]
//  MANT_W  32  raw mantissa width; bits [MANT_W-1:FRAC_W+1] are carry/overflow bits
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   reset, asynchronous, active-high
//  in_valid    in   1   raw sum present
//  in_ready    out  1   block can accept (high only in IDLE)
//  in_sign     in   1   result sign from add stage
//  in_exp      in   8   biased exponent of larger operand
//  in_mant     in   32  raw magnitude, nominal 1.0 = 32'h0080_0000
//  out_valid   out  1   out_result/out_ovf valid
//  out_ready   in   1   consumer accepts result
//  out_result  out  32  {sign, exp[7:0], frac[22:0]}
//  out_ovf     out  1   result overflowed to infinity
// BEHAVIOUR
//  Reset (async): state=IDLE, in_ready=1, out_valid=0, out_result=0, out_ovf=0, internal regs 0.
//  Reset mid-operation aborts in-flight value; nothing emitted.
//  States: IDLE, NORM, ROUND, DONE.
//  IDLE: in_ready=1. On edge with in_valid: latch sign/exp/mant, guard=sticky=0, -> NORM.
//  NORM (one action per cycle, priority order):
//   - in_exp==255 (inf/NaN): pack {sign,8'hFF,mant[22:0]} -> DONE, no rounding.
//   - mant==0: result 32'h0000_0000 (+0, sign forced 0) -> DONE.
//   - any of mant[31:24] set: mant>>=1, sticky|=guard, guard=dropped bit, exp+=1;
//     if new exp==255: result {sign,8'hFF,23'b0}, out_ovf=1 -> DONE.
//   - mant[23]==0 and exp>1: mant<<=1 (zero fill), exp-=1.
//   - else -> ROUND.
//  ROUND: up = guard & (sticky | mant[0]); mant+=up.
//   - carry into bit 24: frac=0, exp+=1; exp==255 -> infinity, out_ovf=1.
//   - exp==1 and mant[23]==0: subnormal, pack exp field 0.
//   - pack {sign, exp, mant[22:0]} -> DONE.
//  DONE: out_valid=1; out_result/out_ovf stable while out_valid & !out_ready.
//   On edge with out_ready: out_valid=0, -> IDLE (no same-cycle accept; in_ready low in DONE).
//  Latency (accept edge to out_valid high): zero/inf 1 cycle; normalised input 2 cycles;
//   +1 cycle per shift (max 8 right or 23 left).
//  Left shifts never follow a right shift; guard/sticky only set by right shifts.
//  in_* ignored outside IDLE; in_valid held across busy period is accepted after return to IDLE.
// TESTING
//  1.0+1.0: exp=127, mant=32'h0100_0000 -> 32'h4000_0000, out_valid 3 cycles after accept.
//  Normalised: exp=127, mant=32'h00C0_0000 -> 32'h3FC0_0000 after 2 cycles; backpressure
//   out_ready=0 for 5 cycles -> output held, in_ready stays 0.
//  Cancellation: exp=127, mant=32'h0000_0001 -> 23 left shifts, 32'h3400_0000, latency 25.
//  Zero/denormal: mant=0 -> 32'h0 after 1 cycle; exp=3, mant=32'h0010_0000 -> 32'h0040_0000.
//  Overflow: exp=254, mant=32'h0100_0000, sign=1 -> 32'hFF80_0000, out_ovf=1.
//  RNE carry: exp=127, mant=32'h01FF_FFFF -> 32'h4080_0000; assert rst during NORM -> out_valid
//   never rises, in_ready=1 immediately.

Source files
------------

// File: rtl/fpa_normalize_pack.sv
// FP adder back end: normalise a raw signed-magnitude sum one shift
// per cycle, round to nearest even and pack an IEEE-754 single.
module fpa_normalize_pack #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int MANT_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sign,
    input  logic [EXP_W-1:0]          in_exp,
    input  logic [MANT_W-1:0]         in_mant,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     out_result,
    output logic                      out_ovf
);

    localparam int RES_W = 1 + EXP_W + FRAC_W;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t            state, state_n;
    logic              sign_q, sign_n;
    logic [EXP_W-1:0]  exp_q, exp_n;
    logic [MANT_W-1:0] mant_q, mant_n;
    logic              guard_q, guard_n;
    logic              sticky_q, sticky_n;
    logic [RES_W-1:0]  res_q, res_n;
    logic              ovf_q, ovf_n;

    logic [EXP_W-1:0]  exp_inc;
    logic              mant_hi;
    logic              round_up;
    logic [FRAC_W+1:0] mant_rnd;

    // mant_hi: any carry bit above the hidden bit is set
    assign exp_inc  = exp_q + EXP_ONE;
    assign mant_hi  = |mant_q[MANT_W-1:FRAC_W+1];
    assign round_up = guard_q & (sticky_q | mant_q[0]);
    assign mant_rnd = mant_q[FRAC_W+1:0] + (FRAC_W+2)'(round_up);

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign out_result = res_q;
    assign out_ovf    = ovf_q;

    // State and datapath registers; reset drops any in-flight value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state    <= state_n;
            sign_q   <= sign_n;
            exp_q    <= exp_n;
            mant_q   <= mant_n;
            guard_q  <= guard_n;
            sticky_q <= sticky_n;
            res_q    <= res_n;
            ovf_q    <= ovf_n;
        end
    end

    // Next state: one normalising action per cycle, then round and pack
    always_comb begin
        state_n  = state;
        sign_n   = sign_q;
        exp_n    = exp_q;
        mant_n   = mant_q;
        guard_n  = guard_q;
        sticky_n = sticky_q;
        res_n    = res_q;
        ovf_n    = ovf_q;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    sign_n   = in_sign;
                    exp_n    = in_exp;
                    mant_n   = in_mant;
                    guard_n  = 1'b0;
                    sticky_n = 1'b0;
                    ovf_n    = 1'b0;
                    state_n  = NORM;
                end
            end
            NORM: begin
                if (exp_q == EXP_MAX) begin
                    // inf/NaN passes through unrounded
                    res_n   = {sign_q, EXP_MAX, mant_q[FRAC_W-1:0]};
                    state_n = DONE;
                end else if (mant_q == '0) begin
                    res_n   = '0;
                    state_n = DONE;
                end else if (mant_hi) begin
                    mant_n   = mant_q >> 1;
                    guard_n  = mant_q[0];
                    sticky_n = sticky_q | guard_q;
                    exp_n    = exp_inc;
                    if (exp_inc == EXP_MAX) begin
                        res_n   = {sign_q, EXP_MAX, {FRAC_W{1'b0}}};
                        ovf_n   = 1'b1;
                        state_n = DONE;
                    end
                end else if (!mant_q[FRAC_W] && (exp_q > EXP_ONE)) begin
                    mant_n = mant_q << 1;
                    exp_n  = exp_q - EXP_ONE;
                end else begin
                    state_n = ROUND;
                end
            end
            ROUND: begin
                state_n = DONE;
                if (mant_rnd[FRAC_W+1]) begin
                    if (exp_inc == EXP_MAX) begin
                        res_n = {sign_q, EXP_MAX, {FRAC_W{1'b0}}};
                        ovf_n = 1'b1;
                    end else begin
                        res_n = {sign_q, exp_inc, {FRAC_W{1'b0}}};
                    end
                end else if ((exp_q == EXP_ONE) && !mant_rnd[FRAC_W]) begin
                    // no hidden bit at minimum exponent: subnormal
                    res_n = {sign_q, {EXP_W{1'b0}}, mant_rnd[FRAC_W-1:0]};
                end else begin
                    res_n = {sign_q, exp_q, mant_rnd[FRAC_W-1:0]};
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
